// File: rtl/score_collector.sv
// rtl/score_collector.sv - per-port score FIFOs, round-robin merge onto the shared score bus
//
// Purpose:
//   Buffers score words from P compute tiles in per-port FIFOs and re-broadcasts
//   them one word per cycle on the shared score bus, round-robin between ports.
//   Counts broadcast words so the Nth word of every iteration is flagged.
//
// Ports:
//   clk             clock
//   reset           asynchronous, active-high reset
//   i_wr_en[P]      per-port write strobe
//   i_wr_data[P*W]  per-port word, port k at [k*W +: W]; bit 0 of a word is its valid bit
//   o_bcast_valid   o_bcast_data carries a word this cycle
//   o_bcast_data    broadcast word, all-zero when idle
//   o_round_done    one-cycle pulse alongside the Nth word of an iteration
//   o_overflow[P]   sticky per-port "word dropped on full FIFO"
//   o_dup_err       sticky duplicate/out-of-range node flag
//
// Build option:
//   SCORE_COLLECTOR_CHECK_EN  keep an N-bit node coverage bitmap and drive o_dup_err;
//                             when undefined o_dup_err is tied low.

module score_collector #(
   parameter int P     = 4,
   parameter int W     = 31,
   parameter int N     = 64,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [P-1:0]     i_wr_en,
   input  logic [P*W-1:0]   i_wr_data,
   output logic             o_bcast_valid,
   output logic [W-1:0]     o_bcast_data,
   output logic             o_round_done,
   output logic [P-1:0]     o_overflow,
   output logic             o_dup_err
);

   localparam int PW = (P > 1) ? $clog2(P) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = (N > 1) ? $clog2(N) : 1;

   logic [W-1:0]  r_mem  [P][DEPTH];
   logic [AW-1:0] r_wptr [P];
   logic [AW-1:0] r_rptr [P];
   logic [CW-1:0] r_cnt  [P];
   logic [P-1:0]  r_overflow;
   logic [PW-1:0] r_rr_ptr;
   logic [RW-1:0] r_rcnt;
   logic          r_bcast_valid;
   logic [W-1:0]  r_bcast_data;
   logic          r_round_done;

   logic [P-1:0]  w_push_req;
   logic [P-1:0]  w_nonempty;
   logic [P-1:0]  w_full;
   logic [P-1:0]  w_pop;
   logic [P-1:0]  w_push;
   logic [P-1:0]  w_drop;
   logic          w_grant;
   logic [PW-1:0] w_gnt_idx;
   logic [W-1:0]  w_head;
   logic          w_last;

   // Per-port status; eligibility comes from the registered count, so a word
   // written into an empty FIFO is not poppable until the following cycle.
   always_comb begin
      for (int k = 0; k < P; k++) begin
         w_push_req[k] = i_wr_en[k] & i_wr_data[k*W];
         w_nonempty[k] = (r_cnt[k] != '0);
         w_full[k]     = (r_cnt[k] == CW'(DEPTH));
      end
   end

   // Round-robin: first non-empty port scanning cyclically after the last grant.
   always_comb begin
      int v_idx;
      w_grant   = 1'b0;
      w_gnt_idx = r_rr_ptr;
      v_idx     = 0;
      for (int i = 1; i <= P; i++) begin
         v_idx = (int'(r_rr_ptr) + i) % P;
         if (!w_grant && w_nonempty[v_idx[PW-1:0]]) begin
            w_grant   = 1'b1;
            w_gnt_idx = v_idx[PW-1:0];
         end
      end
   end

   // A full FIFO still accepts a push when it is popped on the same edge.
   always_comb begin
      for (int k = 0; k < P; k++) begin
         w_pop[k]  = w_grant && (w_gnt_idx == PW'(k));
         w_push[k] = w_push_req[k] & (~w_full[k] | w_pop[k]);
         w_drop[k] = w_push_req[k] & w_full[k] & ~w_pop[k];
      end
   end

   assign w_head = r_mem[w_gnt_idx][r_rptr[w_gnt_idx]];
   assign w_last = (r_rcnt == RW'(N - 1));

   // Storage array carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      for (int k = 0; k < P; k++) begin
         if (w_push[k]) begin
            r_mem[k][r_wptr[k]] <= i_wr_data[k*W +: W];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < P; k++) begin
            r_wptr[k] <= '0;
            r_rptr[k] <= '0;
            r_cnt[k]  <= '0;
         end
         r_overflow <= '0;
      end else begin
         for (int k = 0; k < P; k++) begin
            if (w_push[k]) begin
               r_wptr[k] <= r_wptr[k] + AW'(1);
            end
            if (w_pop[k]) begin
               r_rptr[k] <= r_rptr[k] + AW'(1);
            end
            if (w_push[k] && !w_pop[k]) begin
               r_cnt[k] <= r_cnt[k] + CW'(1);
            end else if (!w_push[k] && w_pop[k]) begin
               r_cnt[k] <= r_cnt[k] - CW'(1);
            end
            if (w_drop[k]) begin
               r_overflow[k] <= 1'b1;
            end
         end
      end
   end

   // Output register, arbiter pointer and round counter all advance on a grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr_ptr      <= PW'(P - 1);
         r_rcnt        <= '0;
         r_bcast_valid <= 1'b0;
         r_bcast_data  <= '0;
         r_round_done  <= 1'b0;
      end else if (w_grant) begin
         r_rr_ptr      <= w_gnt_idx;
         r_rcnt        <= w_last ? '0 : r_rcnt + RW'(1);
         r_bcast_valid <= 1'b1;
         r_bcast_data  <= w_head;
         r_round_done  <= w_last;
      end else begin
         r_bcast_valid <= 1'b0;
         r_bcast_data  <= '0;
         r_round_done  <= 1'b0;
      end
   end

   assign o_bcast_valid = r_bcast_valid;
   assign o_bcast_data  = r_bcast_data;
   assign o_round_done  = r_round_done;
   assign o_overflow    = r_overflow;

`ifdef SCORE_COLLECTOR_CHECK_EN
   logic [N-1:0] r_bitmap;
   logic         r_dup_err;
   logic [5:0]   w_node;
   logic         w_dup;

   assign w_node = w_head[6:1];

   // Out-of-range node numbers count as duplicates.
   always_comb begin
      w_dup = 1'b0;
      if (int'(w_node) >= N) begin
         w_dup = 1'b1;
      end else begin
         w_dup = r_bitmap[w_node];
      end
   end

   // The last word of an iteration is checked against the bitmap before it clears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bitmap  <= '0;
         r_dup_err <= 1'b0;
      end else if (w_grant) begin
         if (w_dup) begin
            r_dup_err <= 1'b1;
         end
         if (w_last) begin
            r_bitmap <= '0;
         end else if (int'(w_node) < N) begin
            r_bitmap[w_node] <= 1'b1;
         end
      end
   end

   assign o_dup_err = r_dup_err;
`else
   assign o_dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_score_collector.sv
// tb/tb_score_collector.sv - self-checking bench for score_collector
module tb_score_collector;

   localparam int P     = 4;
   localparam int W     = 31;
   localparam int N     = 64;
   localparam int DEPTH = 16;

`ifdef SCORE_COLLECTOR_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic           clk;
   logic           reset;
   logic [P-1:0]   wr_en;
   logic [P*W-1:0] wr_data;
   logic           bcast_valid;
   logic [W-1:0]   bcast_data;
   logic           round_done;
   logic [P-1:0]   overflow;
   logic           dup_err;

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   score_collector #(.P(P), .W(W), .N(N), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_wr_en      (wr_en),
      .i_wr_data    (wr_data),
      .o_bcast_valid(bcast_valid),
      .o_bcast_data (bcast_data),
      .o_round_done (round_done),
      .o_overflow   (overflow),
      .o_dup_err    (dup_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] mk(input logic [23:0] score, input int node);
      logic [5:0] n;
      n = node[5:0];
      return {score, n, 1'b1};
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      reset   = 1'b1;
      wr_en   = '0;
      wr_data = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (bcast_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bcast_valid); end
      checks++; if (bcast_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", bcast_data); end
      checks++; if (round_done !== 1'b0) begin failures++; $display("FAIL reset_round_done got=%b exp=0", round_done); end
      checks++; if (overflow !== '0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      checks++; if (dup_err !== 1'b0) begin failures++; $display("FAIL reset_dup_err got=%b exp=0", dup_err); end
      reset = 1'b0;
   endtask

   task automatic test_single_port();
      logic exp_v;
      logic [W-1:0] e;
      logic [W-1:0] w;
      apply_reset();
      for (int c = 0; c < 22; c++) begin
         @(negedge clk);
         exp_v = (c >= 2 && c < 18);
         checks++;
         if (bcast_valid !== exp_v) begin failures++; $display("FAIL single_valid c=%0d got=%b exp=%b", c, bcast_valid, exp_v); end
         checks++;
         if (bcast_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (bcast_data !== e) begin failures++; $display("FAIL single_data c=%0d got=%h exp=%h", c, bcast_data, e); end
         end else if (bcast_data !== '0) begin
            failures++; $display("FAIL single_idle_data c=%0d got=%h exp=0", c, bcast_data);
         end
         if (c < 16) begin
            w = mk(24'h040000, c);
            wr_data = '0;
            wr_data[0 +: W] = w;
            wr_en = 4'b0001;
            exp_q.push_back(w);
         end else begin
            wr_en = '0;
            wr_data = '0;
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_leftover got=%0d exp=0", exp_q.size()); end
   endtask

   // Four ports push 16 words each in the same 16 cycles; broadcast order is
   // port0,1,2,3 per input cycle, and round_done rides on the 64th word.
   task automatic run_round(input string tag);
      int nword;
      logic exp_v;
      logic exp_rd;
      logic [W-1:0] e;
      logic [W-1:0] w;
      nword = 0;
      for (int c = 0; c < 72; c++) begin
         @(negedge clk);
         exp_v = (c >= 2 && c < 66);
         checks++;
         if (bcast_valid !== exp_v) begin failures++; $display("FAIL %s_valid c=%0d got=%b exp=%b", tag, c, bcast_valid, exp_v); end
         if (bcast_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL %s_data c=%0d got=%h exp=none", tag, c, bcast_data);
            end else begin
               e = exp_q.pop_front();
               if (bcast_data !== e) begin failures++; $display("FAIL %s_data c=%0d got=%h exp=%h", tag, c, bcast_data, e); end
            end
            exp_rd = (nword == N - 1);
            checks++;
            if (round_done !== exp_rd) begin failures++; $display("FAIL %s_round_done word=%0d got=%b exp=%b", tag, nword, round_done, exp_rd); end
            nword++;
         end else begin
            checks++;
            if (bcast_data !== '0 || round_done !== 1'b0) begin
               failures++; $display("FAIL %s_idle c=%0d got data=%h rd=%b exp 0/0", tag, c, bcast_data, round_done);
            end
         end
         if (c < 16) begin
            for (int k = 0; k < P; k++) begin
               w = mk(24'h100000 + 24'(c) + 24'(k << 8), 16 * k + c);
               wr_data[k*W +: W] = w;
               exp_q.push_back(w);
            end
            wr_en = '1;
         end else begin
            wr_en = '0;
            wr_data = '0;
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL %s_leftover got=%0d exp=0", tag, exp_q.size()); end
   endtask

   task automatic test_all_ports();
      apply_reset();
      run_round("all_ports");
      checks++; if (overflow !== '0) begin failures++; $display("FAIL all_ports_overflow got=%b exp=0", overflow); end
   endtask

   task automatic test_invalid_ignored();
      apply_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (bcast_valid !== 1'b0) begin failures++; $display("FAIL invalid_valid c=%0d got=%b exp=0", c, bcast_valid); end
         if (c < 3) begin
            wr_en = '1;
            for (int k = 0; k < P; k++) wr_data[k*W +: W] = 31'h0000_0080;
         end else begin
            wr_en = '0;
            wr_data = '0;
         end
      end
      run_round("after_invalid");
   endtask

   // All ports keep busy so port2 gets one grant in four cycles; ports 0,1,3
   // push 20 words, port2 pushes 22 and fills on edge 20, so its word 21 drops.
   task automatic test_overflow();
      int nbc;
      logic [W-1:0] dropped;
      dropped = mk({8'd2, 16'd21}, 21);
      nbc = 0;
      apply_reset();
      for (int c = 0; c < 160; c++) begin
         @(negedge clk);
         if (bcast_valid === 1'b1) begin
            nbc++;
            checks++;
            if (bcast_data === dropped) begin failures++; $display("FAIL overflow_dropped_seen c=%0d got=%h exp=not %h", c, bcast_data, dropped); end
         end
         for (int k = 0; k < P; k++) begin
            wr_en[k] = (k == 2) ? (c < 22) : (c < 20);
            wr_data[k*W +: W] = mk({8'(k), 16'(c)}, c);
         end
      end
      checks++; if (overflow !== 4'b0100) begin failures++; $display("FAIL overflow_flags got=%b exp=0100", overflow); end
      checks++; if (nbc != 81) begin failures++; $display("FAIL overflow_count got=%0d exp=81", nbc); end
      wr_en = '0;
      wr_data = '0;
   endtask

   task automatic test_dup();
      int nodes [5];
      logic [W-1:0] e;
      logic [W-1:0] w;
      nodes = '{5, 6, 5, 7, 8};
      apply_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bcast_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bcast_data !== e) begin failures++; $display("FAIL dup_data c=%0d got=%h exp=%h", c, bcast_data, e); end
         end
         if (c == 3) begin
            checks++;
            if (dup_err !== 1'b0) begin failures++; $display("FAIL dup_early c=%0d got=%b exp=0", c, dup_err); end
         end
         if (c == 9) begin
            checks++;
            if (dup_err !== CHECK_EN) begin failures++; $display("FAIL dup_err got=%b exp=%b", dup_err, CHECK_EN); end
         end
         if (c < 5) begin
            w = mk(24'h020000 + 24'(c), nodes[c]);
            wr_data = '0;
            wr_data[0 +: W] = w;
            wr_en = 4'b0001;
            exp_q.push_back(w);
         end else begin
            wr_en = '0;
            wr_data = '0;
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         wr_en = '1;
         for (int k = 0; k < P; k++) wr_data[k*W +: W] = mk(24'h0A0000 + 24'(c), 16 * k + c);
      end
      @(negedge clk);
      wr_en = '0;
      wr_data = '0;
      reset = 1'b1;
      #1;
      checks++; if (bcast_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bcast_valid); end
      checks++; if (bcast_data !== '0) begin failures++; $display("FAIL midrst_data got=%h exp=0", bcast_data); end
      checks++; if (round_done !== 1'b0) begin failures++; $display("FAIL midrst_round_done got=%b exp=0", round_done); end
      checks++; if (overflow !== '0) begin failures++; $display("FAIL midrst_overflow got=%b exp=0", overflow); end
      checks++; if (dup_err !== 1'b0) begin failures++; $display("FAIL midrst_dup_err got=%b exp=0", dup_err); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checks++;
         if (bcast_valid !== 1'b0) begin failures++; $display("FAIL midrst_residue c=%0d got=%b exp=0", c, bcast_valid); end
      end
      run_round("after_reset");
   endtask

   initial begin
      reset   = 1'b1;
      wr_en   = '0;
      wr_data = '0;
      test_reset();
      test_single_port();
      test_all_ports();
      test_invalid_ignored();
      test_overflow();
      test_dup();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
